pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-stage register for the pipelined CPU; replaces the hand-written per-stage latches (IF/ID, ID/EX, ...).
- Carries an arbitrary-width payload with valid/ready handshakes on both sides, plus the global Pause (hold) and Flush (kill) controls.
- A one-entry skid buffer keeps in_ready registered, so no combinational ready path runs back through the stage.
- Invalid slots present a configurable NOP payload downstream.

Parameters:
- DATA_W, 64, payload width in bits (default fits {pc4[31:0], inst[31:0]}).
- NOP_VAL, {32'h0, 32'h0000_0013}, payload driven on out_data whenever out_valid=0 and loaded on reset/flush (addi x0,x0,0).
- CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- Pause  in  1  hold: freezes all state, no transfers on either side.
- Flush  in  1  synchronous kill of all stage contents; priority over Pause.
- in_valid  in  1  upstream payload valid.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept this cycle.
- out_valid  out  1  stage holds a valid payload.
- out_data  out  DATA_W  payload, or NOP_VAL when out_valid=0.
- out_ready  in  1  downstream accepts this cycle.

Behaviour:
- Storage: main entry (main_v, main_d) and skid entry (skid_v, skid_d).
- Reset (async, rst=1): main_v=0, skid_v=0, main_d=NOP_VAL, skid_d=0. Outputs: out_valid=0, out_data=NOP_VAL, in_ready=1 once rst deasserts.
- Reset mid-operation discards both entries immediately, without waiting for a clock edge.
- in_ready = ~skid_v & ~Pause & ~Flush.
- push = in_valid & in_ready.
- pop = main_v & out_ready & ~Pause & ~Flush.
- out_valid = main_v. out_data = main_v ? main_d : NOP_VAL.
- Latency: a payload accepted at edge N appears on out_data after edge N (one cycle) when the stage is empty. Order is strictly FIFO.
- States are encoded by {skid_v, main_v}:
  - EMPTY (00): push -> FULL, main <- in.
  - FULL (01):
    - push & pop -> FULL, main <- in.
    - push & ~pop -> SKID, skid <- in.
    - ~push & pop -> EMPTY.
    - neither -> hold.
  - SKID (11): push is impossible (in_ready=0). pop -> FULL, main <- skid, skid_v <- 0. Otherwise hold.
  - State 10 is illegal. It is never reachable; an assertion is required.
- Pause=1 (and Flush=0): all registers hold; in_ready=0; out_valid/out_data remain stable.
- Flush=1: at the next edge main_v=0, skid_v=0, main_d=NOP_VAL. A concurrent in_valid payload is dropped and no pop is reported. Flush overrides Pause. in_ready=1 in the cycle after.
- Data registers update only on the transitions listed above; they never change while their valid bit is 0, except on reset or flush.
- Throughput: one payload per cycle sustained when out_ready=1 continuously.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- With the macro defined, the following ports are added:
  - perf_clr  in  1  synchronous clear.
  - stall_cnt  out  CNT_W
  - bubble_cnt  out  CNT_W
  - flush_cnt  out  CNT_W
- Counter rules:
  - stall_cnt: +1 each cycle main_v & ~pop & ~Flush.
  - bubble_cnt: +1 each cycle ~main_v & ~Pause & ~Flush.
  - flush_cnt: +1 each cycle Flush=1.
- All counters saturate at all-ones and reset to 0 on rst. perf_clr clears them and takes priority over incrementing.
- Without the macro: no extra ports, no counter logic, and the behaviour is otherwise identical.

Test Plan:
- Reset: assert rst mid-stream with the stage in SKID -> out_valid=0, out_data=64'h0000_0000_0000_0013 immediately. in_ready=1 after release.
- Streaming: in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later, in_ready stays 1.
- Back-pressure/skid: push A, B with out_ready=0 -> state SKID, in_ready=0, out_data=A. Raise out_ready -> A then B emerge, in_ready returns to 1 after A pops.
- Pause: hold Pause=1 for 3 cycles with in_valid=1, out_ready=1, main=X -> out_data=X stable, in_ready=0, nothing consumed. Release -> X pops, then next input flows.
- Flush vs Pause: stage in SKID, assert Flush=1 and Pause=1 with in_valid=1 data C -> next cycle out_valid=0, out_data=NOP_VAL, C lost, in_ready=1.
- Perf (PIPE_STAGE_PERF_EN, CNT_W=4): hold a stall for 20 cycles -> stall_cnt saturates at 4'hF. Pulse perf_clr -> all counters 0 next cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline-stage register with valid/ready on both
// sides, global Pause (hold) and Flush (kill), and a one-entry skid buffer so
// in_ready is a pure function of registered state plus the global controls.
// Invalid slots present NOP_VAL downstream.
// Optional feature: define PIPE_STAGE_PERF_EN to add saturating
// stall/bubble/flush counters, the perf_clr input and the CNT_W parameter.
//
// state | meaning
// EMPTY | {skid_v, main_v} = 00, no payload held
// FULL  | {skid_v, main_v} = 01, main entry holds the head payload
// SKID  | {skid_v, main_v} = 11, main is the head, skid holds the next one
module pipe_stage_reg #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = {32'h0, 32'h0000_0013}
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int                CNT_W   = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Pause,
  input  logic              Flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
`ifdef PIPE_STAGE_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // Encoding doubles as the valid bits: bit1 = skid_v, bit0 = main_v.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_main_d;
  logic [DATA_W-1:0] r_skid_d;

  logic [1:0] w_state_bits;
  logic       w_main_v;
  logic       w_skid_v;
  logic       w_in_ready;
  logic       w_push;
  logic       w_pop;

  assign w_state_bits = r_state;
  assign w_main_v     = w_state_bits[0];
  assign w_skid_v     = w_state_bits[1];

  assign w_in_ready = ~w_skid_v & ~Pause & ~Flush;
  assign w_push     = in_valid & w_in_ready;
  assign w_pop      = w_main_v & out_ready & ~Pause & ~Flush;

  assign in_ready  = w_in_ready;
  assign out_valid = w_main_v;
  assign out_data  = w_main_v ? r_main_d : NOP_VAL;

  // Occupancy FSM and payload storage; Flush wins over Pause, Pause freezes all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= EMPTY;
      r_main_d <= NOP_VAL;
      r_skid_d <= '0;
    end else if (Flush) begin
      r_state  <= EMPTY;
      r_main_d <= NOP_VAL;
    end else if (!Pause) begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_state  <= FULL;
            r_main_d <= in_data;
          end
        end
        FULL: begin
          if (w_push && w_pop) begin
            r_main_d <= in_data;
          end else if (w_push) begin
            r_state  <= SKID;
            r_skid_d <= in_data;
          end else if (w_pop) begin
            r_state  <= EMPTY;
          end
        end
        SKID: begin
          // in_ready is low here, so only the drain path exists.
          if (w_pop) begin
            r_state  <= FULL;
            r_main_d <= r_skid_d;
          end
        end
        default: begin
          r_state  <= EMPTY;
          r_main_d <= NOP_VAL;
        end
      endcase
    end
  end

  // A skid entry without a main entry would reorder payloads; it must never occur.
  a_no_skid_without_main: assert property (
    @(posedge clk) disable iff (rst) w_state_bits != 2'b10
  );

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_inc;
  logic             w_bubble_inc;
  logic             w_flush_inc;

  assign w_stall_inc  = w_main_v & ~w_pop & ~Flush;
  assign w_bubble_inc = ~w_main_v & ~Pause & ~Flush;
  assign w_flush_inc  = Flush;

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;

  // Saturating event counters; perf_clr beats any increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (perf_clr) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_bubble_inc && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      if (w_flush_inc && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. A queue holds the payloads the
// stage should contain; it is pushed when the bench drives an accepted
// payload and popped when the downstream side consumes one.
module tb_pipe_stage_reg;
  localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        Pause;
  logic        Flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
`ifdef PIPE_STAGE_PERF_EN
  logic        perf_clr;
  logic [3:0]  stall_cnt;
  logic [3:0]  bubble_cnt;
  logic [3:0]  flush_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] q[$];
  logic [65:0] obs;
  logic [65:0] expv;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W (64),
    .NOP_VAL(NOP)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .CNT_W  (4)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Pause    (Pause),
    .Flush    (Flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_clr  (perf_clr),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // Model expectations derived from the bench queue and current controls.
  function automatic logic [65:0] model_exp();
    logic r;
    logic v;
    logic [63:0] d;
    r = (q.size() < 2) && !Pause && !Flush;
    v = (q.size() > 0);
    d = v ? q[0] : NOP;
    return {r, v, d};
  endfunction

  task automatic drive(input logic v, input logic [63:0] d, input logic ordy,
                       input logic p, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    Pause     = p;
    Flush     = f;
  endtask

  // Apply the current inputs to the model, then move past the next rising edge.
  task automatic advance();
    bit do_push;
    bit do_pop;
    if (Flush) begin
      q.delete();
    end else if (!Pause) begin
      do_push = in_valid && (q.size() < 2);
      do_pop  = (q.size() > 0) && out_ready;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_data} !== {1'b0, NOP}) begin
      errors++;
      $display("FAIL reset_hold: got v=%b d=%h want v=0 d=%h", out_valid, out_data, NOP);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    q.delete();
    // Fill to SKID, then reset between edges.
    drive(1'b1, 64'hA0A0, 1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b1, 64'hB0B0, 1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    obs = {in_ready, out_valid, out_data};
    expv = model_exp();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL reset_pre_skid: got %h want %h", obs, expv);
    end
    #1 rst = 1'b1;
    #1;
    q.delete();
    checks++;
    if ({out_valid, out_data} !== {1'b0, NOP}) begin
      errors++;
      $display("FAIL reset_async: got v=%b d=%h want v=0 d=%h", out_valid, out_data, NOP);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) drive(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
      else        drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      obs = {in_ready, out_valid, out_data};
      expv = model_exp();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL stream_cyc%0d: got %h want %h", i, obs, expv);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] vals [2];
    vals[0] = 64'hAAAA_0001;
    vals[1] = 64'hBBBB_0002;
    for (int i = 0; i < 6; i++) begin
      if (i < 2) drive(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
      else if (i == 2) drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      else drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      obs = {in_ready, out_valid, out_data};
      expv = model_exp();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL skid_cyc%0d: got %h want %h", i, obs, expv);
      end
      advance();
    end
  endtask

  task automatic test_pause();
    drive(1'b1, 64'hCAFE_0000, 1'b0, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 6; i++) begin
      if (i < 3)       drive(1'b1, 64'hD00D, 1'b1, 1'b1, 1'b0);
      else if (i == 3) drive(1'b1, 64'hD00D, 1'b1, 1'b0, 1'b0);
      else             drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      obs = {in_ready, out_valid, out_data};
      expv = model_exp();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL pause_cyc%0d: got %h want %h", i, obs, expv);
      end
      advance();
    end
  endtask

  task automatic test_flush_pause();
    drive(1'b1, 64'h1111, 1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b1, 64'h2222, 1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b1, 64'hC0C0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    obs = {in_ready, out_valid, out_data};
    expv = model_exp();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL flush_during: got %h want %h", obs, expv);
    end
    advance();
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b0, NOP}) begin
      errors++;
      $display("FAIL flush_after: got r=%b v=%b d=%h want r=1 v=0 d=%h",
               in_ready, out_valid, out_data, NOP);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom},
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 24) == 0));
      @(negedge clk);
      obs = {in_ready, out_valid, out_data};
      expv = model_exp();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random_cyc%0d: got %h want %h", i, obs, expv);
      end
      advance();
    end
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    advance();
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    perf_clr = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    advance();
    perf_clr = 1'b0;
    drive(1'b1, 64'h5555, 1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    repeat (20) advance();
    checks++;
    if ({stall_cnt, bubble_cnt, flush_cnt} !== {4'hF, 4'h1, 4'h0}) begin
      errors++;
      $display("FAIL perf_stall_sat: got s=%h b=%h f=%h want s=f b=1 f=0",
               stall_cnt, bubble_cnt, flush_cnt);
    end
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    advance();
    checks++;
    if ({stall_cnt, flush_cnt} !== {4'hF, 4'h1}) begin
      errors++;
      $display("FAIL perf_flush: got s=%h f=%h want s=f f=1", stall_cnt, flush_cnt);
    end
    perf_clr = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    advance();
    checks++;
    if ({stall_cnt, bubble_cnt, flush_cnt} !== 12'h000) begin
      errors++;
      $display("FAIL perf_clr: got s=%h b=%h f=%h want 0 0 0",
               stall_cnt, bubble_cnt, flush_cnt);
    end
    perf_clr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_back_to_back();
    test_pause();
    test_flush_pause();
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
